// File: rtl/mem_dma_master_if.sv
// picorv32-style native memory bus between one initiator and its responders.
// Request fields are driven by the master; ready/rdata come back from the slave.
interface mem_dma_master_if;
  logic        mem_valid;
  logic        mem_instr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid,
    output mem_instr,
    output mem_wstrb,
    output mem_addr,
    output mem_wdata,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_valid,
    input  mem_instr,
    input  mem_wstrb,
    input  mem_addr,
    input  mem_wdata,
    output mem_ready,
    output mem_rdata
  );
endinterface

// File: rtl/mem_dma_master.sv
// Word-copy DMA initiator: reads N words from src and writes them to dst,
// one transaction at a time, with a mandatory idle cycle between requests.
module mem_dma_master #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] word_count,
  output logic             busy,
  output logic             done,
  mem_dma_master_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RD_GAP,
    S_WR,
    S_WR_GAP,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [31:0]      r_src;
  logic [31:0]      r_dst;
  logic [LEN_W-1:0] r_cnt;
  logic [31:0]      r_buf;
  logic             r_busy;
  logic             r_done;
  logic             r_valid;
  logic [3:0]       r_wstrb;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;

  logic             w_hs;
  logic [LEN_W-1:0] w_cnt_nxt;
  logic [31:0]      w_src_al;
  logic [31:0]      w_dst_al;
  logic             w_unused;

  // ready only counts while a request is actually on the bus
  assign w_hs      = r_valid & bus.mem_ready;
  assign w_cnt_nxt = r_cnt - 1'b1;
  assign w_src_al  = {src_addr[31:2], 2'b00};
  assign w_dst_al  = {dst_addr[31:2], 2'b00};
  assign w_unused  = &{1'b0, src_addr[1:0], dst_addr[1:0]};

  assign busy          = r_busy;
  assign done          = r_done;
  assign bus.mem_valid = r_valid;
  assign bus.mem_instr = 1'b0;
  assign bus.mem_wstrb = r_wstrb;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_cnt   <= '0;
      r_buf   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      r_wstrb <= 4'h0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_src <= w_src_al;
            r_dst <= w_dst_al;
            r_cnt <= word_count;
            if (word_count == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RD;
              r_busy  <= 1'b1;
              r_valid <= 1'b1;
              r_wstrb <= 4'h0;
              r_addr  <= w_src_al;
            end
          end
        end
        S_RD: begin
          if (w_hs) begin
            r_buf   <= bus.mem_rdata;
            r_valid <= 1'b0;
            r_state <= S_RD_GAP;
          end
        end
        S_RD_GAP: begin
          r_state <= S_WR;
          r_valid <= 1'b1;
          r_wstrb <= 4'hF;
          r_addr  <= r_dst;
          r_wdata <= r_buf;
        end
        S_WR: begin
          if (w_hs) begin
            r_valid <= 1'b0;
            r_wstrb <= 4'h0;
            r_src   <= r_src + 32'd4;
            r_dst   <= r_dst + 32'd4;
            r_cnt   <= w_cnt_nxt;
            if (w_cnt_nxt == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_WR_GAP;
            end
          end
        end
        S_WR_GAP: begin
          r_state <= S_RD;
          r_valid <= 1'b1;
          r_wstrb <= 4'h0;
          r_addr  <= r_src;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dma_master.sv
// Bench for mem_dma_master: responder model, expected-transaction queue,
// and a negedge monitor that checks every completed bus transaction.
module tb_mem_dma_master;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [15:0] word_count = '0;
  logic        busy;
  logic        done;

  mem_dma_master_if bus();

  mem_dma_master #(.LEN_W(16)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem  [0:4095];
  logic [31:0] gold [0:4095];
  txn_t        exp_q[$];

  bit          rand_ws = 1'b0;
  int unsigned wcnt;
  logic        pre_en = 1'b0;
  logic [31:0] pre_addr = '0;
  logic [31:0] pre_data = '0;

  function automatic int idx(input logic [31:0] a);
    return int'(a[13:2]);
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // responder: ready is registered from valid and stays high one stale
  // cycle after a completion, which the master must ignore
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.mem_ready <= 1'b0;
      bus.mem_rdata <= '0;
      wcnt          <= 0;
    end else begin
      if (bus.mem_valid && bus.mem_ready) begin
        if (bus.mem_wstrb == 4'hF)
          mem[idx(bus.mem_addr)] <= bus.mem_wdata;
      end else if (bus.mem_valid) begin
        if (wcnt == 0) begin
          bus.mem_ready <= 1'b1;
          bus.mem_rdata <= mem[idx(bus.mem_addr)];
        end else begin
          wcnt <= wcnt - 1;
        end
      end else begin
        bus.mem_ready <= 1'b0;
        wcnt <= rand_ws ? $urandom_range(0, 3) : 0;
      end
    end
    if (pre_en) mem[idx(pre_addr)] <= pre_data;
  end

  // monitor
  int          done_cnt = 0;
  int          done_at = 0;
  bit          busy_seen = 1'b0;
  bit          valid_seen = 1'b0;
  logic        p_valid = 1'b0;
  logic        p_hs = 1'b0;
  logic [31:0] p_addr = '0;
  logic [31:0] p_wdata = '0;
  logic [3:0]  p_wstrb = '0;

  always @(negedge clk) begin
    txn_t e;
    if (!resetn) begin
      p_valid = 1'b0;
      p_hs    = 1'b0;
    end else begin
      if (p_hs) check("gap_valid_low", {31'b0, bus.mem_valid}, 32'd0);
      if (bus.mem_valid) begin
        valid_seen = 1'b1;
        check("addr_aligned", {30'b0, bus.mem_addr[1:0]}, 32'd0);
        check("instr_zero", {31'b0, bus.mem_instr}, 32'd0);
        if (p_valid && !p_hs) begin
          check("stable_addr", bus.mem_addr, p_addr);
          check("stable_wstrb", {28'b0, bus.mem_wstrb}, {28'b0, p_wstrb});
          check("stable_wdata", bus.mem_wdata, p_wdata);
        end
      end
      if (bus.mem_valid && bus.mem_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_txn", bus.mem_addr, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("txn_addr", bus.mem_addr, e.addr);
          check("txn_wstrb", {28'b0, bus.mem_wstrb}, {28'b0, e.wstrb});
          if (e.wstrb == 4'hF) check("txn_wdata", bus.mem_wdata, e.wdata);
        end
      end
      if (done) begin
        done_cnt++;
        done_at = cyc + 1;
        check("busy_low_at_done", {31'b0, busy}, 32'd0);
      end
      if (busy) busy_seen = 1'b1;
      p_valid = bus.mem_valid;
      p_hs    = bus.mem_valid & bus.mem_ready;
      p_addr  = bus.mem_addr;
      p_wdata = bus.mem_wdata;
      p_wstrb = bus.mem_wstrb;
    end
  end

  int t_acc = 0;

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_en = 1'b1;
    pre_addr = a;
    pre_data = d;
    gold[idx(a)] = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic issue(input logic [31:0] s, input logic [31:0] d,
                       input int n);
    logic [31:0] sa;
    logic [31:0] da;
    txn_t t;
    sa = {s[31:2], 2'b00};
    da = {d[31:2], 2'b00};
    @(negedge clk);
    src_addr = s;
    dst_addr = d;
    word_count = 16'(n);
    start = 1'b1;
    for (int i = 0; i < n; i++) begin
      t.addr = sa + 32'(4 * i);
      t.wstrb = 4'h0;
      t.wdata = '0;
      exp_q.push_back(t);
      t.addr = da + 32'(4 * i);
      t.wstrb = 4'hF;
      t.wdata = gold[idx(sa + 32'(4 * i))];
      exp_q.push_back(t);
    end
    @(posedge clk);
    #1;
    t_acc = cyc;
    start = 1'b0;
    check("busy_on_accept", {31'b0, busy}, {31'b0, n != 0});
  endtask

  task automatic wait_done(input int max_cyc);
    int d0;
    bit got;
    d0 = done_cnt;
    got = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk);
      if (done_cnt > d0) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i] = '0;
      gold[i] = '0;
    end
    repeat (2) @(negedge clk);
    check("rst_valid", {31'b0, bus.mem_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_wstrb", {28'b0, bus.mem_wstrb}, 32'd0);
    check("rst_addr", bus.mem_addr, 32'd0);
    check("rst_wdata", bus.mem_wdata, 32'd0);
    resetn = 1'b1;

    // basic 3-word copy, 1 wait state
    preload(32'h100, 32'hAAAA_0001);
    preload(32'h104, 32'hBBBB_0002);
    preload(32'h108, 32'hCCCC_0003);
    issue(32'h100, 32'h200, 3);
    wait_done(200);
    check("t1_latency", 32'(done_at - t_acc), 32'd18);
    check("t1_w0", mem[idx(32'h200)], 32'hAAAA_0001);
    check("t1_w1", mem[idx(32'h204)], 32'hBBBB_0002);
    check("t1_w2", mem[idx(32'h208)], 32'hCCCC_0003);

    // zero length
    repeat (2) @(negedge clk);
    busy_seen = 1'b0;
    valid_seen = 1'b0;
    issue(32'h100, 32'h200, 0);
    check("t2_done_t1", {31'b0, done}, 32'd1);
    wait_done(10);
    check("t2_latency", 32'(done_at - t_acc), 32'd1);
    repeat (3) @(negedge clk);
    check("t2_done_pulse", {31'b0, done}, 32'd0);
    check("t2_no_valid", {31'b0, valid_seen}, 32'd0);
    check("t2_no_busy", {31'b0, busy_seen}, 32'd0);

    // random wait states, 8 words
    for (int i = 0; i < 8; i++)
      preload(32'h400 + 32'(4 * i), 32'h5A00_0000 + 32'(i * 32'h111));
    rand_ws = 1'b1;
    issue(32'h400, 32'h600, 8);
    wait_done(1000);
    for (int i = 0; i < 8; i++)
      check("t3_data", mem[idx(32'h600 + 32'(4 * i))],
            32'h5A00_0000 + 32'(i * 32'h111));
    rand_ws = 1'b0;

    // address wrap and unaligned destination
    preload(32'hFFFF_FFFC, 32'h1234_5678);
    preload(32'h0000_0000, 32'h9ABC_DEF0);
    issue(32'hFFFF_FFFC, 32'h0000_1003, 2);
    wait_done(200);
    check("t4_w0", mem[idx(32'h1000)], 32'h1234_5678);
    check("t4_w1", mem[idx(32'h1004)], 32'h9ABC_DEF0);

    // start pulsed mid-copy must be ignored
    preload(32'h800, 32'h0800_0001);
    preload(32'h804, 32'h0800_0002);
    preload(32'h808, 32'h0800_0003);
    preload(32'hE00, 32'hDEAD_BEEF);
    issue(32'h800, 32'hA00, 3);
    begin
      int d0;
      d0 = done_cnt;
      repeat (8) @(negedge clk);
      src_addr = 32'hC00;
      dst_addr = 32'hE00;
      word_count = 16'd5;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(200);
      check("t5_latency", 32'(done_at - t_acc), 32'd18);
      repeat (10) @(negedge clk);
      check("t5_one_done", 32'(done_cnt - d0), 32'd1);
      check("t5_w0", mem[idx(32'hA00)], 32'h0800_0001);
      check("t5_w2", mem[idx(32'hA08)], 32'h0800_0003);
      check("t5_untouched", mem[idx(32'hE00)], 32'hDEAD_BEEF);
      check("t5_no_busy", {31'b0, busy}, 32'd0);
    end

    // async reset during a write
    preload(32'h300, 32'h0300_0001);
    preload(32'h304, 32'h0300_0002);
    issue(32'h300, 32'h380, 2);
    begin
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (bus.mem_valid && bus.mem_wstrb == 4'hF) begin
          hit = 1'b1;
          break;
        end
      end
      check("t6_reached_wr", {31'b0, hit}, 32'd1);
    end
    resetn = 1'b0;
    #1;
    check("t6_valid_async", {31'b0, bus.mem_valid}, 32'd0);
    check("t6_busy_async", {31'b0, busy}, 32'd0);
    check("t6_done_async", {31'b0, done}, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    busy_seen = 1'b0;
    valid_seen = 1'b0;
    repeat (6) @(negedge clk);
    check("t6_idle_valid", {31'b0, valid_seen}, 32'd0);
    check("t6_idle_busy", {31'b0, busy_seen}, 32'd0);
    issue(32'h304, 32'h390, 1);
    wait_done(100);
    check("t6_latency", 32'(done_at - t_acc), 32'd6);
    check("t6_after", mem[idx(32'h390)], 32'h0300_0002);

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
